// File: rtl/fabric_clk_monitor.sv
// fabric_clk_monitor: frequency supervisor for a fabric clock.
// Counts rising edges of an asynchronous test clock over a fixed gate window
// of clk cycles, qualifies each count against [MIN_COUNT, MAX_COUNT] and
// holds the fabric reset (rst_out) until GOOD_WINDOWS consecutive in-band
// windows have been seen.
// Optional feature macro: FABRIC_CLK_MONITOR_STICKY_FAULT_EN
//   defined   -> loss of lock latches a FAULT state until clear_fault
//   undefined -> loss of lock drops back to ACQUIRE with a one-cycle fault pulse
module fabric_clk_monitor #(
  parameter int GATE_CYCLES  = 50000,
  parameter int CNT_W        = 16,
  parameter int MIN_COUNT    = 19800,
  parameter int MAX_COUNT    = 20200,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_in,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             fault,
  output logic             rst_out
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int STRK_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;
`ifdef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
  localparam logic [1:0] ST_FAULT = 2'd3;
`endif

  logic [2:0]        sync_q;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [CNT_W-1:0]  meas_q, meas_d;
  logic              valid_q;
  logic [1:0]        state_q, state_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic              freq_ok_q, freq_ok_d;
  logic              fault_q, fault_d;

  logic              strobe;
  logic              terminal;
  logic [CNT_W-1:0]  close_count;
  logic              in_band;
  logic [STRK_W-1:0] streak_inc;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  // A saturated count means the true count is unknown, so it never qualifies.
  function automatic logic band_check(input logic [CNT_W-1:0] v);
    band_check = !(&v) && (v >= CNT_W'(MIN_COUNT)) && (v <= CNT_W'(MAX_COUNT));
  endfunction

  assign strobe      = sync_q[1] & ~sync_q[2];
  assign terminal    = (gate_q == GATE_W'(GATE_CYCLES - 1));
  // An edge strobe on the terminal cycle still belongs to the closing window.
  assign close_count = strobe ? sat_inc(edge_q) : edge_q;
  assign in_band     = band_check(close_count);
  assign streak_inc  = streak_q + 1'b1;

  // Two-FF synchronizer plus a third stage for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], test_in};
  end

  // Free-running gate and edge counters; windows are back-to-back.
  always_comb begin
    gate_d = terminal ? '0 : gate_q + 1'b1;
    edge_d = edge_q;
    meas_d = meas_q;
    if (terminal) begin
      edge_d = '0;
      meas_d = close_count;
    end else if (strobe) begin
      edge_d = sat_inc(edge_q);
    end
  end

  // Qualification state machine; only window closes (and clear) move it.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
`ifdef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
    fault_d  = fault_q;
`else
    fault_d  = 1'b0;
`endif
    case (state_q)
      ST_WAIT: begin
        // First window is discarded while the synchronizer settles.
        if (terminal) begin
          state_d  = ST_ACQ;
          streak_d = '0;
        end
      end
      ST_ACQ: begin
        if (terminal) begin
          if (in_band) begin
            streak_d = streak_inc;
            if (streak_inc == STRK_W'(GOOD_WINDOWS)) state_d = ST_LOCK;
          end else begin
            streak_d = '0;
          end
        end
      end
      ST_LOCK: begin
        if (terminal && !in_band) begin
          streak_d = '0;
          fault_d  = 1'b1;
`ifdef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
          state_d  = ST_FAULT;
`else
          state_d  = ST_ACQ;
`endif
        end
      end
`ifdef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
      ST_FAULT: begin
        // Clear wins over a coincident window close; that result is dropped.
        if (clear_fault) begin
          state_d  = ST_ACQ;
          streak_d = '0;
          fault_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = ST_WAIT;
        streak_d = '0;
      end
    endcase
    freq_ok_d = (state_d == ST_LOCK);
  end

`ifndef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
  logic unused_clear_fault;
  assign unused_clear_fault = clear_fault;
`endif

  // State, counter and output registers; rst abandons the current window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q    <= '0;
      edge_q    <= '0;
      meas_q    <= '0;
      valid_q   <= 1'b0;
      state_q   <= ST_WAIT;
      streak_q  <= '0;
      freq_ok_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      meas_q    <= meas_d;
      valid_q   <= terminal;
      state_q   <= state_d;
      streak_q  <= streak_d;
      freq_ok_q <= freq_ok_d;
      fault_q   <= fault_d;
    end
  end

  assign meas_count = meas_q;
  assign meas_valid = valid_q;
  assign freq_ok    = freq_ok_q;
  assign fault      = fault_q;
  assign rst_out    = ~freq_ok_q;

endmodule

// File: tb/tb_fabric_clk_monitor.sv
// Directed bench for fabric_clk_monitor (GATE_CYCLES=100, GOOD_WINDOWS=2,
// band 18..22). A second instance with CNT_W=5 covers counter saturation.
module tb_fabric_clk_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tin = 1'b0;
  logic       tin_s = 1'b0;
  logic       clear_fault = 1'b0;
  logic [7:0] meas_count;
  logic       meas_valid, freq_ok, fault, rst_out;
  logic [4:0] s_meas_count;
  logic       s_meas_valid, s_freq_ok, s_fault, s_rst_out;

  int per = 5;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #10 clk = ~clk;

  fabric_clk_monitor #(
    .GATE_CYCLES(100), .CNT_W(8), .MIN_COUNT(18), .MAX_COUNT(22), .GOOD_WINDOWS(2)
  ) u_dut (
    .clk(clk), .rst(rst), .test_in(tin), .clear_fault(clear_fault),
    .meas_count(meas_count), .meas_valid(meas_valid), .freq_ok(freq_ok),
    .fault(fault), .rst_out(rst_out)
  );

  fabric_clk_monitor #(
    .GATE_CYCLES(100), .CNT_W(5), .MIN_COUNT(18), .MAX_COUNT(22), .GOOD_WINDOWS(2)
  ) u_sat (
    .clk(clk), .rst(rst), .test_in(tin_s), .clear_fault(1'b0),
    .meas_count(s_meas_count), .meas_valid(s_meas_valid), .freq_ok(s_freq_ok),
    .fault(s_fault), .rst_out(s_rst_out)
  );

  // Cycles since reset release: after the Nth rising edge cyc == N.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Test clock generator for the main DUT: period 'per' clk cycles, 0 = stopped.
  initial begin
    int ph;
    int lastp;
    ph = 0;
    lastp = -1;
    forever begin
      @(negedge clk);
      if (per != lastp) begin
        ph = 0;
        lastp = per;
      end else if (per != 0) begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
      end
      tin = (per != 0) && (ph < per / 2);
    end
  end

  // Fixed period-3 test clock for the saturation instance.
  initial begin
    int phs;
    phs = 0;
    forever begin
      @(negedge clk);
      phs = (phs + 1 >= 3) ? 0 : phs + 1;
      tin_s = (phs == 0);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the cycle where meas_valid is high, sampling 1 ns after posedge.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!meas_valid && n < 300);
    if (!meas_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    #1;
    check("rst_meas_count", meas_count, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_freq_ok", freq_ok, 0);
    check("rst_fault", fault, 0);
    check("rst_rst_out", rst_out, 1);

    // Lock from reset with period 5 (20 edges per window).
    rst = 1'b0;
    wait_valid("lock_w1");
    check("lock_w1_cycle", cyc, 100);
    check("lock_w1_freq_ok", freq_ok, 0);
    @(posedge clk); #1;
    check("valid_is_pulse", meas_valid, 0);
    wait_valid("lock_w2");
    check("lock_w2_count", meas_count, 20);
    check("lock_w2_freq_ok", freq_ok, 0);
    check("sat_count", s_meas_count, 31);
    check("sat_freq_ok", s_freq_ok, 0);
    wait_valid("lock_w3");
    check("lock_w3_count", meas_count, 20);
    check("lock_w3_freq_ok", freq_ok, 1);
    check("lock_w3_rst_out", rst_out, 0);
    check("lock_cycle", cyc + 1, 301);
    check("sat_w3_freq_ok", s_freq_ok, 0);
    check("sat_w3_rst_out", s_rst_out, 1);

    // Loss of lock: stop the monitored clock for a full window.
    per = 0;
    wait_valid("loss");
    check("loss_count_le1", int'(meas_count <= 8'd1), 1);
    check("loss_freq_ok", freq_ok, 0);
    check("loss_fault", fault, 1);
    check("loss_rst_out", rst_out, 1);
    per = 5;
    @(posedge clk); #1;
`ifdef FABRIC_CLK_MONITOR_STICKY_FAULT_EN
    check("sticky_fault_held", fault, 1);
    wait_valid("sticky_inband");
    check("sticky_inband_freq_ok", freq_ok, 0);
    check("sticky_inband_fault", fault, 1);
    check("sticky_inband_rst_out", rst_out, 1);
    @(negedge clk);
    clear_fault = 1'b1;
    @(posedge clk); #1;
    check("clear_fault_drop", fault, 0);
    @(negedge clk);
    clear_fault = 1'b0;
    wait_valid("relock_w1");
    check("relock_w1_freq_ok", freq_ok, 0);
    wait_valid("relock_w2");
    check("relock_w2_freq_ok", freq_ok, 1);
    check("relock_w2_fault", fault, 0);
`else
    check("pulse_fault_drop", fault, 0);
    check("pulse_freq_ok", freq_ok, 0);
    wait_valid("relock_w1");
    check("relock_w1_freq_ok", freq_ok, 0);
    check("relock_w1_fault", fault, 0);
    wait_valid("relock_w2");
    check("relock_w2_freq_ok", freq_ok, 1);
    check("relock_w2_fault", fault, 0);
`endif

    // Reset in the middle of a locked window.
    repeat (50) @(posedge clk);
    #1;
    check("pre_rst_freq_ok", freq_ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_freq_ok", freq_ok, 0);
    check("mid_rst_rst_out", rst_out, 1);
    check("mid_rst_meas_count", meas_count, 0);
    check("mid_rst_meas_valid", meas_valid, 0);
    check("mid_rst_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("post_rst_w1");
    check("post_rst_w1_cycle", cyc, 100);
    check("post_rst_w1_freq_ok", freq_ok, 0);
    wait_valid("post_rst_w2");
    check("post_rst_w2_freq_ok", freq_ok, 0);
    wait_valid("post_rst_w3");
    check("post_rst_w3_freq_ok", freq_ok, 1);

    // Out-of-band acquire: period 4 gives 25 edges, above the band.
    per = 4;
    do_reset();
    wait_valid("oob_w1");
    for (int w = 0; w < 3; w++) begin
      wait_valid("oob");
      check("oob_count", meas_count, 25);
      check("oob_freq_ok", freq_ok, 0);
    end
    per = 5;
    wait_valid("oob_fix_w1");
    check("oob_fix_w1_freq_ok", freq_ok, 0);
    wait_valid("oob_fix_w2");
    check("oob_fix_w2_freq_ok", freq_ok, 1);
    check("oob_fix_w2_rst_out", rst_out, 0);
    check("oob_fix_w2_count", meas_count, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
